// File: rtl/mem_resp_pkg.sv
// Shared state encoding and width helpers for the mem_resp_model memory responder.
// Build option: define MEM_RESP_STATS_EN to add request/hit/miss/error counters to the top.
package mem_resp_pkg;

   localparam int unsigned ADDR_W         = 16;
   localparam int unsigned DATA_W         = 16;
   localparam int unsigned WORDS_PER_LINE = 4;
   localparam int unsigned OFFSET_W       = $clog2(WORDS_PER_LINE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Line index width for a direct-mapped store of 'lines' entries (lines >= 2).
   function automatic int unsigned idx_w(input int unsigned lines);
      return $clog2(lines);
   endfunction

   // Tag takes every byte-address bit above the index.
   function automatic int unsigned tag_w(input int unsigned lines);
      return ADDR_W - 1 - OFFSET_W - idx_w(lines);
   endfunction

   // Miss countdown starts at miss_lat-2, so this width always holds it.
   function automatic int unsigned cnt_w(input int unsigned miss_lat);
      return $clog2(miss_lat);
   endfunction

endpackage

// File: rtl/mem_resp_tagstore.sv
// Direct-mapped tag store: per-line valid bit and tag, combinational lookup,
// synchronous install, valid bits cleared by the asynchronous active-low reset.
module mem_resp_tagstore
   import mem_resp_pkg::*;
#(
   parameter  int unsigned LINES = 8,
   localparam int unsigned IDX_W = idx_w(LINES),
   localparam int unsigned TAG_W = tag_w(LINES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] lookup_idx_i,
   input  logic [TAG_W-1:0] lookup_tag_i,
   output logic             hit_c_o,
   input  logic             install_i,
   input  logic [IDX_W-1:0] install_idx_i,
   input  logic [TAG_W-1:0] install_tag_i
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q [LINES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (install_i) begin
         valid_q[install_idx_i] <= 1'b1;
      end
   end

   // Tags need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (install_i) begin
         tag_q[install_idx_i] <= install_tag_i;
      end
   end

   assign hit_c_o = valid_q[lookup_idx_i] && (tag_q[lookup_idx_i] == lookup_tag_i);

endmodule

// File: rtl/mem_resp_model.sv
// Timing-faithful memory responder: 1-cycle hits, MISS_LAT-cycle misses, flat backing array.
// Build option: MEM_RESP_STATS_EN adds n_req/n_hit/n_miss/n_err counters and a createdump print.
module mem_resp_model
   import mem_resp_pkg::*;
#(
   parameter  int unsigned MEM_WORDS = 1024,
   parameter  int unsigned LINES     = 8,
   parameter  int unsigned MISS_LAT  = 10,
   localparam int unsigned WORD_W    = $clog2(MEM_WORDS),
   localparam int unsigned IDX_W     = idx_w(LINES),
   localparam int unsigned TAG_W     = tag_w(LINES),
   localparam int unsigned CNT_W     = cnt_w(MISS_LAT),
   localparam int unsigned IDX_LSB   = 1 + OFFSET_W,
   localparam int unsigned TAG_LSB   = IDX_LSB + IDX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] DataIn,
   input  logic              Rd,
   input  logic              Wr,
   input  logic              createdump,
   output logic [DATA_W-1:0] DataOut,
   output logic              Done,
   output logic              Stall,
   output logic              CacheHit,
   output logic              Err
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  req_idx_q;
   logic [TAG_W-1:0]  req_tag_q;
   logic [DATA_W-1:0] dout_q;
   logic              done_q, stall_q, hit_q, err_q;
   logic              done_d, stall_d, hit_d;

   logic [DATA_W-1:0] mem_q [MEM_WORDS];

   logic [WORD_W-1:0] word_c;
   logic [IDX_W-1:0]  idx_c;
   logic [TAG_W-1:0]  tag_c;
   logic              open_c, bad_c, accept_c, lookup_hit_c, install_c, mem_we_c;

   assign word_c = Addr[WORD_W:1];
   assign idx_c  = Addr[TAG_LSB-1:IDX_LSB];
   assign tag_c  = Addr[ADDR_W-1:TAG_LSB];

   // Requests are only looked at when not busy; malformed ones change nothing but Err.
   assign open_c   = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign bad_c    = open_c && (Rd || Wr) && ((Rd && Wr) || Addr[0]);
   assign accept_c = open_c && (Rd ^ Wr) && !Addr[0];
   assign mem_we_c = accept_c && Wr && rst;

   mem_resp_tagstore #(
      .LINES (LINES)
   ) u_tags (
      .clk           (clk),
      .rst           (rst),
      .lookup_idx_i  (idx_c),
      .lookup_tag_i  (tag_c),
      .hit_c_o       (lookup_hit_c),
      .install_i     (install_c),
      .install_idx_i (req_idx_q),
      .install_tag_i (req_tag_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      install_c = 1'b0;
      hit_d     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept_c) begin
               if (lookup_hit_c) begin
                  state_d = ST_DONE;
                  hit_d   = 1'b1;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = CNT_W'(MISS_LAT - 2);
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) begin
               state_d   = ST_DONE;
               install_c = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      done_d  = (state_d == ST_DONE);
      stall_d = (state_d == ST_BUSY);
   end

   // Output and request-capture registers; DataOut holds between reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q    <= 1'b0;
         stall_q   <= 1'b0;
         hit_q     <= 1'b0;
         err_q     <= 1'b0;
         dout_q    <= '0;
         req_idx_q <= '0;
         req_tag_q <= '0;
      end else begin
         done_q  <= done_d;
         stall_q <= stall_d;
         hit_q   <= hit_d;
         err_q   <= bad_c;
         if (accept_c) begin
            req_idx_q <= idx_c;
            req_tag_q <= tag_c;
            if (Rd) begin
               dout_q <= mem_q[word_c];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem_q[word_c] <= DataIn;
      end
   end

   assign DataOut  = dout_q;
   assign Done     = done_q;
   assign Stall    = stall_q;
   assign CacheHit = hit_q;
   assign Err      = err_q;

`ifdef MEM_RESP_STATS_EN
   logic [31:0] n_req, n_hit, n_miss, n_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_req  <= '0;
         n_hit  <= '0;
         n_miss <= '0;
         n_err  <= '0;
      end else begin
         if (accept_c)                  n_req  <= n_req + 32'd1;
         if (accept_c && lookup_hit_c)  n_hit  <= n_hit + 32'd1;
         if (accept_c && !lookup_hit_c) n_miss <= n_miss + 32'd1;
         if (bad_c)                     n_err  <= n_err + 32'd1;
      end
   end

   // Simulation-only snapshot of the counters and every live tag line.
   always @(posedge clk) begin
      if (rst && createdump) begin
         $display("mem_resp_model: n_req=%0d n_hit=%0d n_miss=%0d n_err=%0d",
                  n_req, n_hit, n_miss, n_err);
         for (int i = 0; i < int'(LINES); i++) begin
            if (u_tags.valid_q[i]) begin
               $display("mem_resp_model: line %0d tag 0x%0h", i, u_tags.tag_q[i]);
            end
         end
      end
   end
`else
   logic unused_createdump;
   assign unused_createdump = createdump;
`endif

endmodule

// File: tb/tb_mem_resp_model.sv
// Self-checking bench for mem_resp_model: directed vector table, reset-in-flight sequence,
// and a random request trace checked against a shadow array plus a direct-mapped tag model.
`timescale 1ns/1ps
module tb_mem_resp_model;

   localparam int unsigned MEM_WORDS = 1024;
   localparam int unsigned LINES     = 8;
   localparam int unsigned MISS_LAT  = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] Addr = '0;
   logic [15:0] DataIn = '0;
   logic        Rd = 1'b0;
   logic        Wr = 1'b0;
   logic        createdump = 1'b0;
   logic [15:0] DataOut;
   logic        Done, Stall, CacheHit, Err;

   int checks = 0;
   int errors = 0;

   // Reference model: word-addressed shadow memory and direct-mapped line tags.
   logic [15:0] shadow  [MEM_WORDS];
   bit          written [MEM_WORDS];
   bit          mvalid  [LINES];
   int unsigned mtag    [LINES];

   always #5 clk = ~clk;

   mem_resp_model #(
      .MEM_WORDS (MEM_WORDS),
      .LINES     (LINES),
      .MISS_LAT  (MISS_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .Addr       (Addr),
      .DataIn     (DataIn),
      .Rd         (Rd),
      .Wr         (Wr),
      .createdump (createdump),
      .DataOut    (DataOut),
      .Done       (Done),
      .Stall      (Stall),
      .CacheHit   (CacheHit),
      .Err        (Err)
   );

   function automatic int unsigned m_word(input logic [15:0] a);
      return (32'(a) / 2) % MEM_WORDS;
   endfunction
   function automatic int unsigned m_idx(input logic [15:0] a);
      return (32'(a) / 8) % LINES;
   endfunction
   function automatic int unsigned m_tag(input logic [15:0] a);
      return 32'(a) / (8 * LINES);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_tags();
      for (int i = 0; i < int'(LINES); i++) mvalid[i] = 1'b0;
   endtask

   // Entered and left on a negedge; issues one request and checks its whole response.
   task automatic run_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input bit exp_err, input bit exp_hit, input bit chk_data,
                          input logic [15:0] exp_data, input string name);
      int n;
      bit stall_bad;
      Rd = rd; Wr = wr; Addr = a; DataIn = d;
      @(negedge clk);
      Rd = 1'b0; Wr = 1'b0;
      if (exp_err) begin
         check({name, "/err"}, 32'(Err), 32'd1);
         check({name, "/err_nodone"}, 32'(Done), 32'd0);
         @(negedge clk);
         check({name, "/err_pulse"}, 32'(Err), 32'd0);
         check({name, "/err_nodone2"}, 32'(Done), 32'd0);
         return;
      end
      check({name, "/noerr"}, 32'(Err), 32'd0);
      n = 1;
      stall_bad = 1'b0;
      while (!Done && n < 40) begin
         if (!Stall) stall_bad = 1'b1;
         @(negedge clk);
         n++;
      end
      if (Stall) stall_bad = 1'b1;
      check({name, "/latency"}, 32'(n), exp_hit ? 32'd1 : 32'(MISS_LAT));
      check({name, "/cachehit"}, 32'(CacheHit), 32'(exp_hit));
      check({name, "/stall"}, 32'(stall_bad), 32'd0);
      if (rd && chk_data) check({name, "/data"}, 32'(DataOut), 32'(exp_data));
      if (wr) begin
         shadow[m_word(a)]  = d;
         written[m_word(a)] = 1'b1;
      end
      mvalid[m_idx(a)] = 1'b1;
      mtag[m_idx(a)]   = m_tag(a);
   endtask

   typedef struct {
      bit          rd;
      bit          wr;
      logic [15:0] addr;
      logic [15:0] din;
      bit          exp_err;
      bit          exp_hit;
      bit          chk;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs [9];

   initial begin
      vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}; // cold miss
      vecs[1] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000}; // back-to-back write hit
      vecs[2] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000}; // same line hit
      vecs[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hBEEF}; // read-after-write
      vecs[4] = '{1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}; // conflict miss
      vecs[5] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF}; // evicted, still data
      vecs[6] = '{1'b1, 1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000}; // Rd&Wr
      vecs[7] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000}; // odd address
      vecs[8] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}; // errors installed nothing

      for (int i = 0; i < int'(MEM_WORDS); i++) written[i] = 1'b0;
      clear_tags();

      // Reset values
      repeat (2) @(negedge clk);
      check("rst/done", 32'(Done), 32'd0);
      check("rst/stall", 32'(Stall), 32'd0);
      check("rst/cachehit", 32'(CacheHit), 32'd0);
      check("rst/err", 32'(Err), 32'd0);
      check("rst/dataout", 32'(DataOut), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].exp_err,
                 vecs[i].exp_hit, vecs[i].chk, vecs[i].exp_data, $sformatf("vec%0d", i));
      end

      // Reset during the 4th busy cycle of a miss drops the request and clears the tags.
      @(negedge clk);
      Rd = 1'b1; Addr = 16'h0060;
      @(negedge clk);
      Rd = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst/stall_before", 32'(Stall), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("midrst/stall", 32'(Stall), 32'd0);
      check("midrst/done", 32'(Done), 32'd0);
      @(negedge clk);
      check("midrst/no_done_in_reset", 32'(Done), 32'd0);
      rst = 1'b1;
      clear_tags();
      @(negedge clk);
      run_req(1'b1, 1'b0, 16'h0060, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, "midrst/remiss");
      run_req(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b1, 16'hBEEF, "midrst/array_kept");

      // Random trace against the model
      for (int i = 0; i < 2000; i++) begin
         logic [15:0] a, d;
         bit rd, wr, er, eh, ck;
         int unsigned sel;
         sel = $urandom_range(0, 15);
         if (sel == 0) a = 16'($urandom) & 16'hFFFE;
         else          a = 16'($urandom_range(0, 255) * 2);
         d  = 16'($urandom);
         rd = 1'($urandom_range(0, 1));
         wr = !rd;
         if (sel == 1) begin rd = 1'b1; wr = 1'b1; end
         if (sel == 2) a[0] = 1'b1;
         er = (rd && wr) || a[0];
         eh = mvalid[m_idx(a)] && (mtag[m_idx(a)] == m_tag(a));
         ck = rd && written[m_word(a)];
         run_req(rd, wr, a, d, er, eh, ck, shadow[m_word(a)], $sformatf("rnd%0d", i));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            check($sformatf("rnd%0d/done_pulse", i), 32'(Done), 32'd0);
         end
      end

`ifdef MEM_RESP_STATS_EN
      check("stats/req_sum", dut.n_req, dut.n_hit + dut.n_miss);
      createdump = 1'b1;
      @(negedge clk);
      createdump = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
